// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the byte-serial fetch front end.
// Contents: icode constants, the "no register" code, status codes,
// the fetch FSM state type and an icode -> instruction length helper.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_OUT   = 2'd2
  } fetch_state_e;

  // Illegal icodes (C..F) are treated as single-byte so the fetch
  // terminates right after the opcode byte.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:                  instr_len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:      instr_len = 4'd2;
      I_JXX, I_CALL:                         instr_len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:          instr_len = 4'd10;
      default:                               instr_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/ifetch_len_decode.sv
// Combinational length/format decode of a Y86-64 icode.
// Ports:
//   icode      in  4  opcode high nibble
//   len        out 4  instruction length in bytes
//   has_regs   out 1  byte 1 is a register-specifier byte
//   has_valc   out 1  instruction carries an 8-byte constant
//   valc_start out 4  byte index of the first constant byte
module ifetch_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       has_regs,
  output logic       has_valc,
  output logic [3:0] valc_start
);

  always_comb begin
    len        = instr_len(icode);
    has_regs   = 1'b0;
    has_valc   = 1'b0;
    valc_start = 4'd0;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        has_regs = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        has_regs   = 1'b1;
        has_valc   = 1'b1;
        valc_start = 4'd2;
      end
      I_JXX, I_CALL: begin
        has_valc   = 1'b1;
        valc_start = 4'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ifetch_byte_buffer.sv
// Byte-serial Y86-64 instruction fetch. Accepts a PC, reads one byte per
// memory handshake, length-decodes the opcode and presents the assembled
// instruction fields on a valid/ready interface.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   pc_valid/pc/pc_ready        PC request handshake (ready only in IDLE)
//   flush                       abort fetch/output, return to IDLE
//   mem_req/mem_addr            byte read request and address
//   mem_ack/mem_data/mem_err    byte response, data and address error
//   instr_valid/instr_ready     assembled instruction handshake
//   icode/ifun/rA/rB/valC/valP  decoded instruction fields
//   instr_ok/imem_error         legal icode / fetch ended on memory error
module ifetch_byte_buffer
  import y86_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int MAX_LEN = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  input  logic              mem_err,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [63:0]       valC,
  output logic [ADDR_W-1:0] valP,
  output logic              instr_ok,
  output logic              imem_error
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  fetch_state_e      state, state_nx;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt;

  logic [3:0] dec_icode;
  logic [3:0] dec_len;
  logic [3:0] dec_start;
  logic       dec_regs;
  logic       dec_valc;

  logic       first_byte;
  logic       last_byte;
  logic       take_pc;
  logic       take_byte;
  logic       valc_hit;
  logic [2:0] valc_idx;

  // On byte 0 the registered icode is not yet known, so decode the
  // incoming opcode directly; later bytes use the latched icode.
  assign first_byte = (cnt == '0);
  assign dec_icode  = first_byte ? mem_data[7:4] : icode;

  ifetch_len_decode u_len_decode (
    .icode      (dec_icode),
    .len        (dec_len),
    .has_regs   (dec_regs),
    .has_valc   (dec_valc),
    .valc_start (dec_start)
  );

  // flush wins over every same-cycle event, so it gates both transfers.
  assign take_pc   = (state == ST_IDLE)  && pc_valid && !flush;
  assign take_byte = (state == ST_FETCH) && mem_ack  && !flush;
  assign last_byte = (cnt == CNT_W'(dec_len - 4'd1));
  assign valc_hit  = dec_valc && (cnt >= CNT_W'(dec_start));
  assign valc_idx  = 3'(cnt - CNT_W'(dec_start));
  assign mem_addr  = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    pc_ready    = 1'b0;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        pc_ready = rst_n;
        if (take_pc) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (take_byte && (mem_err || last_byte)) state_nx = ST_OUT;
      end
      ST_OUT: begin
        instr_valid = 1'b1;
        if (instr_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      addr_q     <= '0;
      cnt        <= '0;
      icode      <= 4'h0;
      ifun       <= 4'h0;
      rA         <= REG_NONE;
      rB         <= REG_NONE;
      valC       <= 64'd0;
      valP       <= '0;
      instr_ok   <= 1'b0;
      imem_error <= 1'b0;
    end else if (take_pc) begin
      pc_q       <= pc;
      addr_q     <= pc;
      cnt        <= '0;
      icode      <= 4'h0;
      ifun       <= 4'h0;
      rA         <= REG_NONE;
      rB         <= REG_NONE;
      valC       <= 64'd0;
      valP       <= '0;
      instr_ok   <= 1'b0;
      imem_error <= 1'b0;
    end else if (take_byte) begin
      if (mem_err) begin
        // Present a nop-shaped instruction at the faulting PC; the data
        // byte that came with the error is dropped.
        icode      <= I_NOP;
        ifun       <= 4'h0;
        rA         <= REG_NONE;
        rB         <= REG_NONE;
        valC       <= 64'd0;
        valP       <= pc_q;
        instr_ok   <= 1'b1;
        imem_error <= 1'b1;
      end else begin
        addr_q <= addr_q + 1'b1;
        cnt    <= cnt + 1'b1;
        if (first_byte) begin
          icode    <= mem_data[7:4];
          ifun     <= mem_data[3:0];
          instr_ok <= (mem_data[7:4] <= I_POPQ);
        end
        if (dec_regs && (cnt == CNT_W'(1))) begin
          rA <= mem_data[7:4];
          rB <= mem_data[3:0];
        end
        if (valc_hit) valC[{valc_idx, 3'b000} +: 8] <= mem_data;
        if (last_byte) valP <= pc_q + ADDR_W'(dec_len);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_byte_buffer.sv
module tb_ifetch_byte_buffer;

  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pc_valid = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic              pc_ready;
  logic              flush = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [7:0]        mem_data = 8'h00;
  logic              mem_err = 1'b0;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [3:0]        icode, ifun, rA, rB;
  logic [63:0]       valC;
  logic [ADDR_W-1:0] valP;
  logic              instr_ok, imem_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifetch_byte_buffer #(.ADDR_W(ADDR_W), .MAX_LEN(10)) dut (
    .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .mem_err(mem_err), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .instr_ok(instr_ok), .imem_error(imem_error)
  );

  typedef struct {
    logic [63:0] pc;
    logic [79:0] bytes;   // byte k at [8k+7:8k]
    int          n;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        ok;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_pc(input string tag, input logic [63:0] a);
    pc_valid = 1'b1;
    pc = a;
    chk({tag, ".pc_ready"}, pc_ready, 1);
    @(negedge clk);
    pc_valid = 1'b0;
  endtask

  // One byte transfer; mem_addr must hold through every wait cycle.
  task automatic send_byte(input string tag, input logic [63:0] addr, input logic [7:0] d,
                           input logic err, input int delay);
    for (int w = 0; w < delay; w++) begin
      mem_ack = 1'b0;
      chk({tag, ".wait_req"}, mem_req, 1);
      chk({tag, ".wait_addr"}, mem_addr, addr);
      @(negedge clk);
    end
    mem_ack  = 1'b1;
    mem_data = d;
    mem_err  = err;
    chk({tag, ".req"}, mem_req, 1);
    chk({tag, ".addr"}, mem_addr, addr);
    chk({tag, ".early_valid"}, instr_valid, 0);
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_err  = 1'b0;
    mem_data = 8'h00;
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_icode, e_ifun, e_ra, e_rb,
                           input logic [63:0] e_valc, e_valp, input logic e_ok, e_err);
    chk({tag, ".instr_valid"}, instr_valid, 1);
    chk({tag, ".mem_req"}, mem_req, 0);
    chk({tag, ".icode"}, icode, e_icode);
    chk({tag, ".ifun"}, ifun, e_ifun);
    chk({tag, ".rA"}, rA, e_ra);
    chk({tag, ".rB"}, rB, e_rb);
    chk({tag, ".valC"}, valC, e_valc);
    chk({tag, ".valP"}, valP, e_valp);
    chk({tag, ".instr_ok"}, instr_ok, e_ok);
    chk({tag, ".imem_error"}, imem_error, e_err);
  endtask

  task automatic consume(input string tag);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk({tag, ".valid_after"}, instr_valid, 0);
    chk({tag, ".pc_ready_after"}, pc_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{64'h100, 80'h0123456789ABCDEFF030, 10, 4'h3, 4'h0, 4'hF, 4'h0,
                64'h0123456789ABCDEF, 64'h10A, 1'b1};
    vecs[1] = '{64'h1000, 80'h01020304050607081240, 10, 4'h4, 4'h0, 4'h1, 4'h2,
                64'h0102030405060708, 64'h100A, 1'b1};
    vecs[2] = '{64'h50, 80'h00112233445566778873, 9, 4'h7, 4'h3, 4'hF, 4'hF,
                64'h1122334455667788, 64'h59, 1'b1};
    vecs[3] = '{64'h30, 80'h4FB0, 2, 4'hB, 4'h0, 4'h4, 4'hF, 64'h0, 64'h32, 1'b1};
    vecs[4] = '{64'h40, 80'hE0, 1, 4'hE, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 1'b0};
    vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 80'h10, 1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1};
    vecs[6] = '{64'h7, 80'h00, 1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h8, 1'b1};
    vecs[7] = '{64'h60, 80'h90, 1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h61, 1'b1};
    vecs[8] = '{64'h70, 80'h4561, 2, 4'h6, 4'h1, 4'h4, 4'h5, 64'h0, 64'h72, 1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst.pc_ready", pc_ready, 0);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.instr_valid", instr_valid, 0);
    chk("rst.rA", rA, 4'hF);
    chk("rst.rB", rB, 4'hF);
    chk("rst.valC", valC, 0);
    chk("rst.instr_ok", instr_ok, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.pc_ready", pc_ready, 1);

    // Table-driven fetches, ack always high: instr_valid must stay low
    // until the last byte's edge and be high right after it.
    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_pc(tag, vecs[i].pc);
      for (int k = 0; k < vecs[i].n; k++)
        send_byte(tag, vecs[i].pc + 64'(k), vecs[i].bytes[8*k +: 8], 1'b0, 0);
      check_out(tag, vecs[i].icode, vecs[i].ifun, vecs[i].ra, vecs[i].rb,
                vecs[i].valc, vecs[i].valp, vecs[i].ok, 1'b0);
      consume(tag);
    end

    // addq with two wait states per byte
    start_pc("addq", 64'h20);
    send_byte("addq", 64'h20, 8'h60, 1'b0, 2);
    send_byte("addq", 64'h21, 8'h23, 1'b0, 2);
    check_out("addq", 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h22, 1'b1, 1'b0);
    consume("addq");

    // call with 5 cycles of backpressure
    start_pc("call", 64'h0);
    send_byte("call", 64'h0, 8'h80, 1'b0, 0);
    send_byte("call", 64'h1, 8'h40, 1'b0, 0);
    for (int k = 2; k < 9; k++) send_byte("call", 64'(k), 8'h00, 1'b0, 0);
    for (int w = 0; w < 5; w++) begin
      check_out("call_hold", 4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 64'h9, 1'b1, 1'b0);
      chk("call_hold.pc_ready", pc_ready, 0);
      @(negedge clk);
    end
    check_out("call", 4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 64'h9, 1'b1, 1'b0);
    consume("call");

    // mrmovq with an address error on the 4th byte
    start_pc("merr", 64'h200);
    send_byte("merr", 64'h200, 8'h50, 1'b0, 0);
    send_byte("merr", 64'h201, 8'h12, 1'b0, 0);
    send_byte("merr", 64'h202, 8'h34, 1'b0, 0);
    send_byte("merr", 64'h203, 8'hFF, 1'b1, 0);
    for (int w = 0; w < 3; w++) begin
      check_out("merr", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h200, 1'b1, 1'b1);
      @(negedge clk);
    end
    consume("merr");

    // flush coincident with the ack of byte 5
    start_pc("flush", 64'h300);
    for (int k = 0; k < 5; k++) send_byte("flush", 64'h300 + 64'(k), 8'h30, 1'b0, 0);
    mem_ack  = 1'b1;
    mem_data = 8'hAA;
    flush    = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    flush   = 1'b0;
    for (int w = 0; w < 3; w++) begin
      chk("flush.instr_valid", instr_valid, 0);
      chk("flush.mem_req", mem_req, 0);
      chk("flush.pc_ready", pc_ready, 1);
      @(negedge clk);
    end

    // flush in IDLE blocks a coincident pc_valid
    pc_valid = 1'b1;
    pc       = 64'h500;
    flush    = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_idle.mem_req", mem_req, 0);
    chk("flush_idle.pc_ready", pc_ready, 1);

    // flush during OUT wins over instr_ready
    start_pc("flush_out", 64'h90);
    send_byte("flush_out", 64'h90, 8'h10, 1'b0, 0);
    chk("flush_out.valid", instr_valid, 1);
    flush       = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    instr_ready = 1'b0;
    chk("flush_out.valid_after", instr_valid, 0);
    chk("flush_out.pc_ready", pc_ready, 1);

    // asynchronous reset mid-fetch
    start_pc("arst", 64'h400);
    send_byte("arst", 64'h400, 8'h30, 1'b0, 0);
    send_byte("arst", 64'h401, 8'hF0, 1'b0, 0);
    send_byte("arst", 64'h402, 8'h11, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.pc_ready", pc_ready, 0);
    chk("arst.mem_req", mem_req, 0);
    chk("arst.mem_addr", mem_addr, 0);
    chk("arst.instr_valid", instr_valid, 0);
    chk("arst.icode", icode, 0);
    chk("arst.rB", rB, 4'hF);
    chk("arst.valC", valC, 0);
    chk("arst.valP", valP, 0);
    chk("arst.instr_ok", instr_ok, 0);
    chk("arst.imem_error", imem_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst.pc_ready_after", pc_ready, 1);
    chk("arst.mem_req_after", mem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
